// File: rtl/tsp16_pkg.sv
// Shared TSP16 definitions: opcode encodings, instruction field positions,
// and the opcode -> "writes rd" classification used by the writeback stage.
package tsp16_pkg;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_ADD   = 4'h1;
  localparam logic [3:0] OP_SUB   = 4'h2;
  localparam logic [3:0] OP_AND   = 4'h3;
  localparam logic [3:0] OP_LOAD  = 4'h4;
  localparam logic [3:0] OP_STORE = 4'h5;
  localparam logic [3:0] OP_BR    = 4'h6;
  localparam logic [3:0] OP_JMP   = 4'h7;
  localparam logic [3:0] OP_OR    = 4'h8;
  localparam logic [3:0] OP_XOR   = 4'h9;
  localparam logic [3:0] OP_SHL   = 4'hA;
  localparam logic [3:0] OP_LI    = 4'hB;
  localparam logic [3:0] OP_HALT  = 4'hF;

  // Instruction word layout: opcode | rd | rs1 | rs2
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 8;
  localparam int RS1_MSB = 7;
  localparam int RS1_LSB = 4;
  localparam int RS2_MSB = 3;
  localparam int RS2_LSB = 0;

  typedef struct packed {
    logic [3:0] opcode;
    logic [3:0] rd;
    logic [3:0] rs1;
    logic [3:0] rs2;
  } instr_t;

  // True for opcodes whose result lands in rd; reserved codes and HALT never write.
  function automatic logic writes_rd(input logic [3:0] opcode);
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_LOAD,
      OP_OR, OP_XOR, OP_SHL, OP_LI: writes_rd = 1'b1;
      default:                      writes_rd = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// Architectural register file: NUM_RD combinational read ports with
// same-cycle write bypass, one synchronous write port, r0 hardwired to zero.
module regfile_2r1w #(
  parameter int NUM_REGS = 16,
  parameter int DATA_W   = 16,
  parameter int NUM_RD   = 2,
  parameter int AW       = $clog2(NUM_REGS)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           wr_en,
  input  logic [AW-1:0]                  wr_addr,
  input  logic [DATA_W-1:0]              wr_data,
  input  logic [NUM_RD-1:0][AW-1:0]      rd_addr,
  output logic [NUM_RD-1:0][DATA_W-1:0]  rd_data
);

  logic [NUM_REGS-1:0][DATA_W-1:0] mem;

  // Storage update; r0 is never written so it stays at its reset value.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem <= '0;
    end else if (wr_en && wr_addr != '0) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read ports: zero for r0, in-flight write data on address match, else array.
  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    assign rd_data[p] = (rd_addr[p] == '0)                  ? '0      :
                        (wr_en && rd_addr[p] == wr_addr)    ? wr_data :
                                                              mem[rd_addr[p]];
  end

endmodule

// File: rtl/pipeline_writeback.sv
// TSP16 writeback stage: commits memory-stage results into the register file,
// registers the retired instruction for forwarding, counts retirements and
// freezes architectural state once HALT retires.
module pipeline_writeback
  import tsp16_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 16,
  parameter int COUNT_W  = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               memory_done,
  input  logic               memory_is_dependent,
  input  logic [DATA_W-1:0]  memory_result,
  input  logic [15:0]        memory_instr,
  input  logic [3:0]         rs1_addr,
  input  logic [3:0]         rs2_addr,
  output logic [DATA_W-1:0]  rs1_data,
  output logic [DATA_W-1:0]  rs2_data,
  output logic               writeback_done,
  output logic               writeback_is_dependent,
  output logic [DATA_W-1:0]  writeback_result,
  output logic [15:0]        writeback_instr,
  output logic [COUNT_W-1:0] retired_count,
  output logic               halted
);

  localparam int AW = $clog2(NUM_REGS);

  logic [3:0] opcode;
  logic [3:0] rd;
  logic       commit;
  logic       wr_en;

  logic [1:0][AW-1:0]     rd_addr;
  logic [1:0][DATA_W-1:0] rd_data;

  assign opcode = memory_instr[OPC_MSB:OPC_LSB];
  assign rd     = memory_instr[RD_MSB:RD_LSB];

  // Once halted nothing else retires; r0 writes are dropped before the array.
  assign commit = memory_done & ~halted;
  assign wr_en  = commit & writes_rd(opcode) & (rd != 4'd0);

  assign rd_addr[0] = rs1_addr[AW-1:0];
  assign rd_addr[1] = rs2_addr[AW-1:0];
  assign rs1_data   = rd_data[0];
  assign rs2_data   = rd_data[1];

  regfile_2r1w #(
    .NUM_REGS (NUM_REGS),
    .DATA_W   (DATA_W),
    .NUM_RD   (2),
    .AW       (AW)
  ) u_regfile (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (rd[AW-1:0]),
    .wr_data (memory_result),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // Forwarding registers: copy the retiring instruction, bubble to zero otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      writeback_done         <= 1'b0;
      writeback_is_dependent <= 1'b0;
      writeback_result       <= '0;
      writeback_instr        <= '0;
    end else if (commit) begin
      writeback_done         <= 1'b1;
      writeback_is_dependent <= memory_is_dependent;
      writeback_result       <= memory_result;
      writeback_instr        <= memory_instr;
    end else begin
      writeback_done         <= 1'b0;
      writeback_is_dependent <= 1'b0;
      writeback_result       <= '0;
      writeback_instr        <= '0;
    end
  end

  // Retirement counter wraps naturally; HALT is counted, later work is not.
  always_ff @(posedge clk) begin
    if (reset) begin
      retired_count <= '0;
    end else if (commit) begin
      retired_count <= retired_count + 1'b1;
    end
  end

  // Sticky halt flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      halted <= 1'b0;
    end else if (commit && opcode == OP_HALT) begin
      halted <= 1'b1;
    end
  end

endmodule

// File: doc/pipeline_writeback.md
Name: pipeline_writeback

Overview:
- Final (5th) stage of the TSP16 pipeline; consumes the memory stage's registered outputs (memory_done, memory_result, memory_instr).
- Owns the architectural register file: commits results, serves the decode stage's two read ports with same-cycle write bypass, and counts retired instructions.
- Detects HALT and freezes architectural state until reset.

Parameters:
- DATA_W, 16, datapath/register width
- NUM_REGS, 16, architectural registers; r0 reads 0 and ignores writes
- COUNT_W, 16, width of the retired-instruction counter

Ports:
- clk  input  1  system clock, all state updates on posedge
- reset  input  1  synchronous, active-high reset
- memory_done  input  1  memory stage holds a valid instruction this cycle
- memory_is_dependent  input  1  dependency flag from execute, passed through
- memory_result  input  DATA_W  value to commit (ALU result or load data)
- memory_instr  input  16  instruction word; opcode [15:12], rd [11:8], rs1 [7:4], rs2 [3:0]
- rs1_addr  input  4  decode read port 1 address
- rs2_addr  input  4  decode read port 2 address
- rs1_data  output  DATA_W  combinational read port 1
- rs2_data  output  DATA_W  combinational read port 2
- writeback_done  output  1  registered: an instruction retired last edge
- writeback_is_dependent  output  1  registered copy of memory_is_dependent
- writeback_result  output  DATA_W  registered committed value (forwarding source)
- writeback_instr  output  16  registered retired instruction word
- retired_count  output  COUNT_W  instructions retired since reset
- halted  output  1  sticky; set once HALT retires

Behaviour:
- Opcode classes (memory_instr[15:12]): writes rd for 0001 ADD, 0010 SUB, 0011 AND, 0100 LOAD, 1000 OR, 1001 XOR, 1010 SHL, 1011 LI; no write for 0000 NOP, 0101 STORE, 0110 BR, 0111 JMP, 1100-1110 reserved; 1111 HALT.
- commit = memory_done & !halted. wr_en = commit & writes(opcode) & (rd != 0).
- posedge, reset=1: all registers, all registered outputs, retired_count and halted go to 0. Reset takes precedence over a same-cycle commit; the write is dropped.
- posedge, reset=0:
  - wr_en -> regfile[rd] <= memory_result.
  - writeback_done <= commit; when commit, writeback_result/instr/is_dependent <= memory inputs; otherwise all four go to 0 (bubble).
  - commit -> retired_count <= retired_count + 1, modulo 2^COUNT_W (0xFFFF wraps to 0x0000). NOPs with memory_done=1 count; bubbles (memory_done=0) do not.
  - commit & opcode==1111 -> halted <= 1. HALT itself counts as retired.
- halted=1: no register writes, counter frozen, writeback_done held 0, regardless of memory_done. Only reset clears it.
- Read ports: combinational. rsN_data = 0 if rsN_addr==0; else memory_result if wr_en & rsN_addr==rd (bypass); else regfile[rsN_addr]. Both ports may bypass simultaneously.
- Latency: result visible on read ports same cycle via bypass, from the array one cycle later; writeback_* one cycle after memory_* presented.
- No backpressure: the stage accepts every cycle; no stall input.

Decomposition:
- tsp16_pkg (shared): opcode localparams (OP_NOP..OP_HALT), instruction field bit positions, function writes_rd(opcode).
- Sub-module regfile_2r1w: NUM_REGS x DATA_W array, 2 combinational read ports with write bypass, 1 synchronous write port, r0 hardwired 0. pipeline_writeback holds the control logic, counter, halt flag and output registers.

Test Plan:
- Reset, then ADD r3 (instr 0x1300), result 0x00AB, done=1 -> same cycle rs1_addr=3 reads 0x00AB (bypass); next cycle from the array: 0x00AB, writeback_done=1, writeback_result=0x00AB, retired_count=1.
- Write to r0 (instr 0x1000, result 0xFFFF) -> rs1_addr=0 reads 0x0000; retired_count increments.
- STORE (0x5120), BR (0x6000) with done=1 -> no register changes; count +2. done=0 bubble -> count unchanged, writeback_done=0, writeback_result=0.
- LOAD r5 (0x4500, result 0x1234), then HALT (0xF000), then ADD r5 (0x1500, result 0x9999) -> r5 stays 0x1234, halted=1, count stops at value after HALT, writeback_done=0 after HALT.
- Preload retired_count to 0xFFFF via 65535 retiring NOPs + 1 more -> count wraps to 0x0000.
- reset=1 in the same cycle as ADD r7 (0x1700, result 0x5555) -> r7 reads 0, all outputs 0, halted=0.
